fetch_pc_gen: RTL
=================

// Module: fetch_pc_gen
// PURPOSE
//  Fetch-stage PC generator/sequencer: holds architectural fetch PC, issues one imem
//  request at a time, returns (pc, instr) to decode via valid/ready. Accepts NREDIR
//  prioritised redirect channels (trap, branch resolve, ...). Kills in-flight fetches
//  on redirect. Sits between hazard/execute redirect logic and the imem port.
// PARAMETERS
//  XLEN       64             address width
//  RESET_VEC  64'h8000_0000  PC loaded on reset
//  ILEN_BYTES 4              sequential PC increment; power of two
//  NREDIR     3              redirect channels; index 0 = highest priority
// PORTS
//  clk           in   1              clock
//  reset         in   1              synchronous, active-high
//  redir_valid   in   NREDIR         redirect request per channel
//  redir_target  in   NREDIR x XLEN  redirect target per channel
//  req_valid     out  1              imem request valid
//  req_addr      out  XLEN           imem request address
//  req_ready     in   1              imem accepts request this cycle
//  resp_valid    in   1              imem returns data (exactly one per accepted req)
//  resp_data     in   32             instruction word
//  out_valid     out  1              fetched instruction valid to decode
//  out_ready     in   1              decode accepts (low = stall)
//  out_pc        out  XLEN           PC of out_instr
//  out_instr     out  32             instruction word
//  out_fault     out  1              misaligned-fetch fault (FETCH_MISALIGN_EN only; else 0)
// BEHAVIOUR
//  - Reset: state=S_REQ, pc=RESET_VEC, kill=0; outputs req_valid=0, out_valid=0,
//    out_pc=0, out_instr=0, out_fault=0 in reset cycle; req_valid=1 first cycle after.
//  - States: S_REQ (req_valid=1, req_addr=pc), S_WAIT (await resp), S_HOLD (out_valid=1).
//  - S_REQ: req_valid&&req_ready -> S_WAIT. req_addr may change while unaccepted.
//  - S_WAIT: resp_valid && !kill -> latch pc/resp_data to out regs, S_HOLD.
//    resp_valid && kill -> discard, kill<=0, S_REQ.
//  - S_HOLD: out_valid&&out_ready -> pc<=pc+ILEN_BYTES (mod 2^XLEN wrap), S_REQ.
//  - Redirect (any bit set): lowest index wins; pc<=winning target next cycle.
//    S_REQ: if accepted same cycle -> S_WAIT with kill=1; else stay S_REQ, new addr.
//    S_WAIT: kill<=1 (resp_valid same cycle: discard now, go S_REQ, kill stays 0).
//    S_HOLD: held instr dropped (out_valid 0 next cycle) unless out_ready same cycle
//      (handshake completes; consumer flushes it); either way pc<=target, S_REQ.
//    Redirect wins over sequential increment. Back-to-back redirects: latest wins.
//  - Minimum latency: req accept cycle N, resp cycle N+1, out_valid cycle N+2.
//  - reset mid-operation: immediate return to reset state; any later resp_valid for
//    a pre-reset request is a protocol violation by imem (imem reset together).
// CONFIGURATION
//  FETCH_MISALIGN_EN defined: redirect target with target % ILEN_BYTES != 0 issues no
//    request; next cycle S_HOLD with out_valid=1, out_fault=1, out_pc=target,
//    out_instr=0; sequencing stops until a further redirect.
//  Undefined: target low log2(ILEN_BYTES) bits forced to 0; out_fault tied 0.
// STRUCTURE
//  Shared package: fetch_state_e {S_REQ,S_WAIT,S_HOLD}, addr_t (XLEN), PC_RESET const.
//  Sub-module pc_redirect_arb: fixed-priority NREDIR-way select -> {hit, target}.
// TESTING
//  1 reset, req_ready=1, resp 1-cycle, out_ready=1 -> req_addr 0x8000_0000,
//    0x8000_0004, 0x8000_0008 on successive accepts.
//  2 out_ready=0 for 5 cycles in S_HOLD -> out_pc/out_instr stable, no new req.
//  3 redirect ch2=0x8000_1000 during S_WAIT, resp 3 cycles later -> resp discarded,
//    next req_addr 0x8000_1000.
//  4 ch0=0x8000_2000 and ch1=0x8000_3000 same cycle -> next req_addr 0x8000_2000.
//  5 pc=0xFFFF_FFFF_FFFF_FFFC, sequential -> next req_addr 0x0 (wrap).
//  6 FETCH_MISALIGN_EN, redirect to 0x8000_0002 -> out_fault=1, out_pc=0x8000_0002,
//    no req; without macro -> req_addr 0x8000_0000.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package fetch_pc_gen_pkg;

  localparam int ADDR_W = 64;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_pc_redirect_arb.sv
// Fixed-priority redirect select: the lowest-index valid channel supplies the target.
module pc_redirect_arb #(
  parameter int NREDIR = 3,
  parameter int XLEN   = 64
) (
  input  logic [NREDIR-1:0]      valid,
  input  logic [NREDIR*XLEN-1:0] targets,
  output logic                   hit,
  output logic [XLEN-1:0]        target
);

  // Walk from lowest to highest priority so the final write is the winner.
  always_comb begin
    target = '0;
    for (int i = NREDIR - 1; i >= 0; i--) begin
      if (valid[i]) begin
        target = targets[i*XLEN +: XLEN];
      end
    end
  end

  assign hit = |valid;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC sequencer: one outstanding imem request, prioritised redirects with kill.
// Build option FETCH_MISALIGN_EN: misaligned redirect targets raise a fetch fault.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int              XLEN       = ADDR_W,
  parameter logic [XLEN-1:0] RESET_VEC  = PC_RESET,
  parameter int              ILEN_BYTES = 4,
  parameter int              NREDIR     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREDIR-1:0]      redir_valid,
  input  logic [NREDIR*XLEN-1:0] redir_target,
  output logic                   req_valid,
  output logic [XLEN-1:0]        req_addr,
  input  logic                   req_ready,
  input  logic                   resp_valid,
  input  logic [31:0]            resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic                   out_fault
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(ILEN_BYTES - 1);
  localparam logic [XLEN-1:0] PC_INC   = XLEN'(ILEN_BYTES);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            kill_reg, kill_next;
  logic [XLEN-1:0] out_pc_reg, out_pc_next;
  logic [31:0]     out_instr_reg, out_instr_next;
  logic            out_fault_reg, out_fault_next;

  logic            redir_hit;
  logic [XLEN-1:0] redir_sel;
  logic [XLEN-1:0] redir_pc;
  logic            redir_misalign;
  logic            fire;

  pc_redirect_arb #(
    .NREDIR (NREDIR),
    .XLEN   (XLEN)
  ) u_arb (
    .valid   (redir_valid),
    .targets (redir_target),
    .hit     (redir_hit),
    .target  (redir_sel)
  );

`ifdef FETCH_MISALIGN_EN
  assign redir_misalign = redir_hit && (|(redir_sel & LOW_MASK));
  assign redir_pc       = redir_sel;
  assign out_fault      = !reset && out_fault_reg;
`else
  assign redir_misalign = 1'b0;
  assign redir_pc       = redir_sel & ~LOW_MASK;
  assign out_fault      = 1'b0;
`endif

  // A killed fetch still owes one response, so no new request until it drains.
  assign req_valid = !reset && (state_reg == S_REQ) && !kill_reg;
  assign req_addr  = pc_reg;
  assign fire      = req_valid && req_ready;
  assign out_valid = !reset && (state_reg == S_HOLD);
  assign out_pc    = reset ? '0 : out_pc_reg;
  assign out_instr = reset ? '0 : out_instr_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    kill_next      = kill_reg && !resp_valid;
    out_pc_next    = out_pc_reg;
    out_instr_next = out_instr_reg;
    out_fault_next = out_fault_reg;

    case (state_reg)
      S_REQ: begin
        if (fire) begin
          state_next = S_WAIT;
        end
        if (redir_hit) begin
          pc_next = redir_pc;
          if (fire) begin
            kill_next = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (redir_hit) begin
          pc_next = redir_pc;
          if (resp_valid) begin
            state_next = S_REQ;
          end else begin
            kill_next = 1'b1;
          end
        end else if (resp_valid) begin
          if (kill_reg) begin
            state_next = S_REQ;
          end else begin
            state_next     = S_HOLD;
            out_pc_next    = pc_reg;
            out_instr_next = resp_data;
            out_fault_next = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (redir_hit) begin
          pc_next    = redir_pc;
          state_next = S_REQ;
        end else if (out_ready && !out_fault_reg) begin
          pc_next    = pc_reg + PC_INC;
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase

    // A faulting target parks the sequencer until the next redirect.
    if (redir_misalign) begin
      state_next     = S_HOLD;
      out_pc_next    = redir_pc;
      out_instr_next = '0;
      out_fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_VEC;
      kill_reg      <= 1'b0;
      out_pc_reg    <= '0;
      out_instr_reg <= '0;
      out_fault_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      kill_reg      <= kill_next;
      out_pc_reg    <= out_pc_next;
      out_instr_reg <= out_instr_next;
      out_fault_reg <= out_fault_next;
    end
  end

endmodule
